// File: rtl/timer_axil_pkg.sv
// Shared definitions for the timer AXI4-Lite front-end.
//   - AXI response codes
//   - write / read sequencer state encodings
//   - byte offsets of the timer registers behind the front-end
package timer_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;

  // Register map of the timer block
  localparam int unsigned CTRL    = 32'h0;
  localparam int unsigned LOAD    = 32'h4;
  localparam int unsigned COUNT   = 32'h8;
  localparam int unsigned IRQSTAT = 32'hC;

endpackage

// File: rtl/timer_axil_addr_chk.sv
// Combinational legality decode for one register access.
// Ports:
//   addr  in  AW      byte address of the access
//   strb  in  DW/8    byte strobes (tie to all-ones for reads)
//   err   out 1       1 = unaligned, beyond the last register, or partial strobe
module timer_axil_addr_chk
  import timer_axil_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DW       = 32,
  parameter int NUM_REGS = 4
) (
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] strb,
  output logic            err
);

  localparam logic [31:0] LIMIT = 32'(NUM_REGS * 4);

  // Widen the address so the range compare works even when NUM_REGS*4
  // does not fit in AW bits.
  logic [31:0] addr_ext;

  always_comb begin
    addr_ext         = '0;
    addr_ext[AW-1:0] = addr;
  end

  assign err = (addr[1:0] != 2'b00) || (addr_ext >= LIMIT) || (strb != '1);

endmodule

// File: rtl/timer_axil_ctrl.sv
// AXI4-Lite slave front-end for the timer register block. Each AXI write or
// read becomes exactly one command on the simple register port; illegal
// accesses are answered with SLVERR without touching the register block.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*                AXI4-Lite write address/data/response
//   s_ar*/s_r*                     AXI4-Lite read address/data
//   reg_wr_addr/data/en, _ready    register write command (en held until ready)
//   reg_rd_addr/en, _data/_valid   register read request and returned data
module timer_axil_ctrl
  import timer_axil_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DW       = 32,
  parameter int NUM_REGS = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   s_awaddr,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [DW-1:0]   s_wdata,
  input  logic [DW/8-1:0] s_wstrb,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [1:0]      s_bresp,
  output logic            s_bvalid,
  input  logic            s_bready,
  input  logic [AW-1:0]   s_araddr,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [AW-1:0]   reg_wr_addr,
  output logic [DW-1:0]   reg_wr_data,
  output logic            reg_wr_en,
  input  logic            reg_wr_ready,
  output logic [AW-1:0]   reg_rd_addr,
  output logic            reg_rd_en,
  input  logic [DW-1:0]   reg_rd_data,
  input  logic            reg_rd_valid
);

  // ---------------- write path ----------------
  wr_state_t       wr_state_reg, wr_state_next;
  logic            aw_held_reg, aw_held_next;
  logic            w_held_reg, w_held_next;
  logic            awready_reg, awready_next;
  logic            wready_reg, wready_next;
  logic [AW-1:0]   awaddr_reg, awaddr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [DW/8-1:0] wstrb_reg, wstrb_next;
  logic [1:0]      bresp_reg, bresp_next;
  logic            wr_err;
  logic            aw_hs, w_hs;

  assign aw_hs = s_awvalid && awready_reg;
  assign w_hs  = s_wvalid && wready_reg;

  timer_axil_addr_chk #(.AW(AW), .DW(DW), .NUM_REGS(NUM_REGS)) u_wr_chk (
    .addr (awaddr_reg),
    .strb (wstrb_reg),
    .err  (wr_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_reg <= W_IDLE;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      bresp_reg    <= bresp_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_held_next  = aw_held_reg;
    w_held_next   = w_held_reg;
    awaddr_next   = awaddr_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    bresp_next    = bresp_reg;
    reg_wr_en     = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        // AW and W are captured independently, in any order.
        if (aw_hs) begin
          awaddr_next  = s_awaddr;
          aw_held_next = 1'b1;
        end
        if (w_hs) begin
          wdata_next  = s_wdata;
          wstrb_next  = s_wstrb;
          w_held_next = 1'b1;
        end
        if (aw_held_next && w_held_next) begin
          wr_state_next = W_EXEC;
        end
      end
      W_EXEC: begin
        if (wr_err) begin
          bresp_next    = RESP_SLVERR;
          wr_state_next = W_RESP;
        end else begin
          reg_wr_en = 1'b1;
          if (reg_wr_ready) begin
            bresp_next    = RESP_OKAY;
            wr_state_next = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_bready) begin
          aw_held_next  = 1'b0;
          w_held_next   = 1'b0;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
    // Readies are registered: open only while idle and not yet captured.
    awready_next = (wr_state_next == W_IDLE) && !aw_held_next;
    wready_next  = (wr_state_next == W_IDLE) && !w_held_next;
  end

  assign s_awready   = awready_reg;
  assign s_wready    = wready_reg;
  assign s_bvalid    = (wr_state_reg == W_RESP);
  assign s_bresp     = bresp_reg;
  assign reg_wr_addr = awaddr_reg;
  assign reg_wr_data = wdata_reg;

  // ---------------- read path ----------------
  rd_state_t     rd_state_reg, rd_state_next;
  logic          arready_reg, arready_next;
  logic [AW-1:0] araddr_reg, araddr_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic [1:0]    rresp_reg, rresp_next;
  logic          rd_err;

  timer_axil_addr_chk #(.AW(AW), .DW(DW), .NUM_REGS(NUM_REGS)) u_rd_chk (
    .addr (araddr_reg),
    .strb ({(DW/8){1'b1}}),
    .err  (rd_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      araddr_reg   <= '0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= arready_next;
      araddr_reg   <= araddr_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    araddr_next   = araddr_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    reg_rd_en     = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (s_arvalid && arready_reg) begin
          araddr_next   = s_araddr;
          rd_state_next = R_EXEC;
        end
      end
      R_EXEC: begin
        if (rd_err) begin
          rdata_next    = '0;
          rresp_next    = RESP_SLVERR;
          rd_state_next = R_RESP;
        end else begin
          reg_rd_en = 1'b1;
          if (reg_rd_valid) begin
            rdata_next    = reg_rd_data;
            rresp_next    = RESP_OKAY;
            rd_state_next = R_RESP;
          end
        end
      end
      R_RESP: begin
        if (s_rready) begin
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
    arready_next = (rd_state_next == R_IDLE);
  end

  assign s_arready   = arready_reg;
  assign s_rvalid    = (rd_state_reg == R_RESP);
  assign s_rdata     = rdata_reg;
  assign s_rresp     = rresp_reg;
  assign reg_rd_addr = araddr_reg;

endmodule

// File: doc/timer_axil_ctrl.md
Name: timer_axil_ctrl

Overview:
AXI4-Lite slave front-end that sequences the timer register block. It accepts independent AXI4-Lite write (AW/W/B) and read (AR/R) transactions and converts each into a single-cycle register-port command on the simple wr_*/rd_* interface. It checks addresses and strobes, returns OKAY/SLVERR responses, and holds responses until the master accepts them. It sits between the system interconnect and the timer register block.

Parameters:
AW, 4, AXI and register address width in bits
DW, 32, data width in bits
NUM_REGS, 4, number of 32-bit registers at offsets 0x0, 0x4, ... up to (NUM_REGS-1)*4

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_awaddr  in  AW  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DW  write data
s_wstrb  in  DW/8  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AW  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DW  read data
s_rresp  out  2  read response
s_rvalid  out  1  read response valid
s_rready  in  1  read response ready
reg_wr_addr  out  AW  register write address
reg_wr_data  out  DW  register write data
reg_wr_en  out  1  register write strobe, one cycle per accepted write
reg_wr_ready  in  1  register block accepts write
reg_rd_addr  out  AW  register read address
reg_rd_en  out  1  register read request
reg_rd_data  in  DW  register read data
reg_rd_valid  in  1  register read data valid

Behaviour:
- One clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - All valid and enable outputs are 0: bvalid, rvalid, reg_wr_en, reg_rd_en.
  - bresp, rresp, rdata and all reg_* address and data outputs are 0.
  - awready, wready and arready are registered. They are 0 in reset and rise on the first clk edge after rstn deasserts.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: awready=1 until the AW beat is captured; wready=1 until the W beat is captured. AW and W may arrive in either order or in the same cycle. Each is latched independently. A captured channel drops its ready.
  - W_IDLE -> W_EXEC on the cycle both channels are held.
  - Error check: addr[1:0]!=0, or addr>=NUM_REGS*4, or wstrb != all-ones. Any of these gives SLVERR (2'b10); otherwise OKAY (2'b00).
  - W_EXEC, no error: drive reg_wr_en=1 with the latched addr and data until reg_wr_ready=1. The write commits on that cycle, then go to W_RESP.
  - W_EXEC, error: reg_wr_en stays 0. Spend exactly one cycle in W_EXEC, then go to W_RESP.
  - W_RESP: bvalid=1 with the latched bresp, held stable until bready. The handshake returns the FSM to W_IDLE, with awready and wready back to 1 on the next cycle.
  - Latency with reg_wr_ready=1: last of AW/W handshake at cycle N, reg_wr_en at N+1, bvalid at N+2. Error writes have the same latency.
- Read FSM states: R_IDLE, R_EXEC, R_RESP.
  - R_IDLE: arready=1. A handshake latches the address and goes to R_EXEC.
  - R_EXEC, no error: reg_rd_en=1 and reg_rd_addr=latched address. rdata is captured on the cycle reg_rd_valid=1, then go to R_RESP. If reg_rd_valid stays 0, wait in R_EXEC.
  - R_EXEC, error (address check as for writes): reg_rd_en stays 0, rdata=0, rresp=SLVERR, one cycle, then R_RESP.
  - R_RESP: rvalid=1 with rdata and rresp stable until rready. Then return to R_IDLE.
  - Latency: AR handshake at N, reg_rd_en at N+1, rvalid at N+2.
- The read and write FSMs are fully independent and may overlap. A read and write to the same register in the same EXEC cycle returns the pre-write value.
- Exactly one register command is issued per AXI transaction. There are no outstanding transactions beyond one write and one read.
- Backpressure: holding bready or rready low stalls only that channel. The other channel continues to accept one new transaction and then blocks in its own RESP state.
- Reset mid-transaction aborts it. There is no response and no register write after release.

Decomposition:
- Package timer_axil_pkg holds:
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - enums wr_state_t {W_IDLE, W_EXEC, W_RESP} and rd_state_t {R_IDLE, R_EXEC, R_RESP};
  - register offsets CTRL=0x0, LOAD=0x4, COUNT=0x8, IRQSTAT=0xC.
- One sub-module, timer_axil_addr_chk: a combinational legality decode of address (and strobe), instanced once for writes and once for reads.
- The two FSMs live in the top module.

Test Plan:
- Reset: rstn=0 mid-simulation -> all valids 0 and readies 0; one cycle after release awready=wready=arready=1.
- Write 0x4=0x0000_1234, AW and W in the same cycle, bready=1 -> reg_wr_en for 1 cycle at N+1 with addr 0x4, data 0x1234; bvalid at N+2, bresp=00.
- W arrives 3 cycles before AW for 0x0=0x1 -> wready drops after W is captured; a single reg_wr_en follows AW; bresp=00.
- Write to 0x6 (unaligned) and to 0x10 (out of range, AW=5 bench), then wstrb=4'b0011 -> no reg_wr_en; bresp=10 each time.
- Read 0x8 with reg_rd_data=0xCAFE_0001 and rready low for 4 cycles -> rvalid held, rdata=0xCAFE_0001 stable, rresp=00; a new AR is not accepted until the R handshake.
- Concurrent write 0xC=0x1 and read 0x0 issued the same cycle -> both reg commands at N+1; bvalid and rvalid both at N+2 with OKAY.
